// File: rtl/b1_queue_pkg.sv
// -----------------------------------------------------------------------------
// b1_queue_pkg
// Shared constants and state type for the B1 sample queue.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package b1_queue_pkg;

  // Default queue depth; equals the FIR tap count.
  localparam int DEPTH_DEF = 1021;
  // Default pointer width; 2**PTR_W must cover DEPTH.
  localparam int PTR_W_DEF = 10;
  // Audio sample width.
  localparam int SMPL_W    = 16;

  // Readout sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/b1_queue_ram.sv
// -----------------------------------------------------------------------------
// b1_queue_ram
// DEPTH x DATA_W storage, one write port, one synchronous read port.
// The read data register resets to zero and holds its value when no read
// is issued; the array itself is not reset.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module b1_queue_ram #(
  parameter int DEPTH  = 1021,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: no reset on the array contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Synchronous read port; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/b1_sample_queue.sv
// -----------------------------------------------------------------------------
// b1_sample_queue
// Circular queue of the most recent DEPTH samples. Once full, every new
// sample triggers a readout of all DEPTH samples oldest-to-newest while
// sequencing is high. Samples arriving during a readout wait in a one-entry
// hold register; a second arrival while it is occupied is dropped and flagged.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module b1_sample_queue
  import b1_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_smpl,
  input  logic [SMPL_W-1:0] smpl_in,
  output logic [SMPL_W-1:0] smpl_out,
  output logic              sequencing,
  output logic              full,
  output logic              overrun
);

  // Counters are one bit wider than the pointers so they can reach DEPTH.
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [PTR_W:0]    fill_cnt;
  logic [PTR_W:0]    fill_inc;
  logic [PTR_W:0]    issued;
  logic              hold_vld;
  logic [SMPL_W-1:0] hold_data;

  logic              do_write;
  logic [SMPL_W-1:0] wr_data;
  logic              do_read;
  logic              full_after;
  logic              capture;
  logic              release_hold;
  logic              drop;

  // Pointers wrap at DEPTH-1 rather than at the power of two.
  assign wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_nxt = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
  assign fill_inc   = fill_cnt + 1'b1;
  assign full_after = full | (fill_inc == DEPTH_CNT);
  assign sequencing = (state == READ);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt    = state;
    do_write     = 1'b0;
    wr_data      = smpl_in;
    do_read      = 1'b0;
    capture      = 1'b0;
    release_hold = 1'b0;
    drop         = 1'b0;
    case (state)
      IDLE: begin
        if (hold_vld || new_smpl) begin
          do_write = 1'b1;
          // The held sample is older, so it goes first.
          if (hold_vld) begin
            wr_data = hold_data;
            if (new_smpl) begin
              capture = 1'b1;
            end else begin
              release_hold = 1'b1;
            end
          end
          if (full_after) begin
            state_nxt = PRIME;
          end
        end
      end
      PRIME: begin
        do_read   = 1'b1;
        state_nxt = READ;
        if (new_smpl) begin
          if (hold_vld) drop = 1'b1;
          else          capture = 1'b1;
        end
      end
      READ: begin
        do_read = (issued < DEPTH_CNT);
        // The data cycle that sees all reads issued is the last one.
        if (issued == DEPTH_CNT) begin
          state_nxt = IDLE;
        end
        if (new_smpl) begin
          if (hold_vld) drop = 1'b1;
          else          capture = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pointers, fill tracking and readout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
      issued   <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr_nxt;
        if (!full) begin
          fill_cnt <= fill_inc;
          full     <= (fill_inc == DEPTH_CNT);
        end
        // The slot after the newest sample holds the oldest one.
        if (full_after) begin
          rd_ptr <= wr_ptr_nxt;
        end
      end
      if (do_read) begin
        rd_ptr <= rd_ptr_nxt;
        issued <= (state == PRIME) ? (PTR_W+1)'(1) : issued + 1'b1;
      end
    end
  end

  // Hold register and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      overrun   <= 1'b0;
    end else begin
      if (capture) begin
        hold_vld  <= 1'b1;
        hold_data <= smpl_in;
      end else if (release_hold) begin
        hold_vld <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  b1_queue_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W),
    .DATA_W (SMPL_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (do_read),
    .raddr (rd_ptr),
    .rdata (smpl_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_b1_sample_queue.sv
// -----------------------------------------------------------------------------
// tb_b1_sample_queue
// Randomised bench for b1_sample_queue with a queue-based reference model
// and a scoreboard monitor.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_b1_sample_queue;

  localparam int DEPTH = 1021;
  localparam int PTR_W = 10;

  logic        clk;
  logic        rst_n;
  logic        new_smpl;
  logic [15:0] smpl_in;
  logic [15:0] smpl_out;
  logic        sequencing;
  logic        full;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  logic [15:0] stored[$];
  logic [15:0] expq[$];
  int          starts[$];
  int          written;
  int          busy_until;
  bit          hold_v;
  logic [15:0] hold_d;
  bit          overrun_exp;

  b1_sample_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_smpl   (new_smpl),
    .smpl_in    (smpl_in),
    .smpl_out   (smpl_out),
    .sequencing (sequencing),
    .full       (full),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    stored.delete();
    expq.delete();
    starts.delete();
    written     = 0;
    busy_until  = 0;
    hold_v      = 1'b0;
    hold_d      = '0;
    overrun_exp = 1'b0;
  endfunction

  // A sample lands in the queue; once DEPTH samples exist, a full readout follows.
  function automatic void model_write(input logic [15:0] x);
    stored.push_back(x);
    if (stored.size() > DEPTH) void'(stored.pop_front());
    written++;
    if (written >= DEPTH) begin
      foreach (stored[i]) expq.push_back(stored[i]);
      starts.push_back(cyc + 2);
      busy_until = cyc + DEPTH + 2;
    end
  endfunction

  // One cycle of model behaviour, given this cycle's inputs.
  function automatic void model_cycle(input bit n, input logic [15:0] v);
    if (cyc >= busy_until) begin
      if (hold_v) begin
        model_write(hold_d);
        if (n) hold_d = v;
        else   hold_v = 1'b0;
      end else if (n) begin
        model_write(v);
      end
    end else if (n) begin
      if (hold_v) overrun_exp = 1'b1;
      else begin
        hold_v = 1'b1;
        hold_d = v;
      end
    end
  endfunction

  task automatic step(input bit n, input logic [15:0] v);
    @(posedge clk);
    #1;
    new_smpl = n;
    smpl_in  = n ? v : 16'($urandom);
    model_cycle(n, v);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 16'h0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4 * DEPTH && (cyc < busy_until || hold_v); i++) step(1'b0, 16'h0);
    idle(4);
  endtask

  task automatic fill(input int k, input bit seq_vals);
    for (int i = 1; i <= k; i++) begin
      step(1'b1, seq_vals ? 16'(i) : 16'($urandom));
      idle($urandom_range(0, 2));
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge.
  initial begin : monitor
    bit prev = 1'b0;
    int run  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        run  = 0;
      end else begin
        if (sequencing) begin
          if (!prev) begin
            if (starts.size() == 0) begin
              checks++; errors++;
              $display("FAIL seq_unexpected actual=1 required=0 (cycle %0d)", cyc);
            end else begin
              chk("seq_start_cycle", cyc, starts.pop_front());
            end
          end
          run++;
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL smpl_out_extra actual=%0d required=none", smpl_out);
          end else begin
            chk("smpl_out", int'(smpl_out), int'(expq.pop_front()));
          end
        end else if (prev) begin
          chk("seq_length", run, DEPTH);
          run = 0;
        end
        prev = sequencing;
      end
    end
  end

  initial begin
    logic [15:0] a;
    rst_n    = 1'b0;
    new_smpl = 1'b0;
    smpl_in  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_smpl_out", int'(smpl_out), 0);
    chk("rst_sequencing", int'(sequencing), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // Fill phase: DEPTH-1 samples, no readout.
    fill(DEPTH - 1, 1'b1);
    idle(20);
    chk("fill_full", int'(full), 0);

    // First readout: 1..DEPTH.
    step(1'b1, 16'(DEPTH));
    step(1'b0, 16'h0);
    chk("full_set", int'(full), 1);
    wait_done();

    // Second readout crosses the pointer wrap.
    step(1'b1, 16'(DEPTH + 1));
    wait_done();

    // One sample held during a readout.
    step(1'b1, 16'($urandom));
    idle(101);
    step(1'b1, 16'd5000);
    wait_done();
    chk("overrun_single_hold", int'(overrun), int'(overrun_exp));
    chk("overrun_still_clear", int'(overrun), 0);

    // Two samples during a readout: second is dropped.
    step(1'b1, 16'($urandom));
    idle(50);
    a = 16'($urandom);
    step(1'b1, a);
    idle(50);
    step(1'b1, 16'($urandom));
    wait_done();
    chk("overrun_set", int'(overrun), int'(overrun_exp));
    step(1'b1, 16'($urandom));
    wait_done();
    chk("overrun_sticky", int'(overrun), 1);

    // Back-to-back random pushes, some colliding with readouts.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'($urandom));
      idle($urandom_range(0, DEPTH + 3));
    end
    wait_done();

    // Reset during a readout.
    step(1'b1, 16'($urandom));
    idle(501);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    new_smpl = 1'b0;
    model_reset();
    #1;
    chk("midrst_sequencing", int'(sequencing), 0);
    chk("midrst_smpl_out", int'(smpl_out), 0);
    chk("midrst_overrun", int'(overrun), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    fill(DEPTH - 1, 1'b0);
    idle(20);
    chk("refill_full", int'(full), 0);
    step(1'b1, 16'($urandom));
    step(1'b0, 16'h0);
    chk("refill_full_set", int'(full), 1);
    wait_done();

    chk("expq_drained", expq.size(), 0);
    chk("starts_drained", starts.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
